led_group_sequencer: RTL
========================

Name: led_group_sequencer

Overview:
- Parametrised LED group driver that moves a lit-group mask across GROUPS groups of GW LEDs.
- Each lit group shows the current pattern `patt`; unlit groups are 0.
- The mask is held or advanced by an internal prescaler, in one of four modes: hold, rotate left, rotate right, bounce.
- Sits between the switch/pattern logic and the board LED pins, replacing fixed position decoding with a self-stepping mask.

Parameters:
GROUPS, 4, number of LED groups (>=2); group GROUPS-1 is leftmost (out MSBs)
GW, 4, LEDs per group (>=1)
DIV, 4, enabled clock cycles per step (>=1)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-high reset
en  input  1  prescaler enable
load  input  1  one-cycle strobe: mask <= mask_in
mask_in  input  GROUPS  mask value to load
mode  input  2  00 hold, 01 rotate left, 10 rotate right, 11 bounce
patt  input  GW  pattern shown in every lit group
out  output  GROUPS*GW  LED drive; group g = out[g*GW+GW-1 : g*GW]
step  output  1  registered one-cycle pulse, high in the first cycle the new mask is visible
step_cnt  output  8  count of steps taken, wraps 255->0

Behaviour:
- Reset (async, rst=1):
  - mask = 1 in bit GROUPS-1, 0 elsewhere
  - dir = right; div_cnt = 0; step = 0; step_cnt = 0
- out is combinational: group g = mask[g] ? patt : 0. There is no latency from patt or mask to out. During reset out = {patt, zeros}.
- Prescaler:
  - mode=00: div_cnt cleared to 0; no ticks.
  - mode!=00 and en=1: if div_cnt==DIV-1, then div_cnt <= 0 and tick=1; otherwise div_cnt increments.
  - en=0: div_cnt holds; no tick.
  - DIV=1: tick on every enabled cycle.
- On each tick, registered at the edge; step is 1 in the following cycle and step_cnt increments:
  - Rotate left: mask <= {mask[GROUPS-2:0], mask[GROUPS-1]}.
  - Rotate right: mask <= {mask[0], mask[GROUPS-1:1]}.
  - Bounce:
    - Uses the dir register; shifts are zero-fill.
    - dir=right and mask[0]=0: shift right.
    - dir=right and mask[0]=1: dir <= left, shift left.
    - dir=left and mask[GROUPS-1]=0: shift left.
    - dir=left and mask[GROUPS-1]=1: dir <= right, shift right.
    - mask[0] and mask[GROUPS-1] both 1: mask holds, dir unchanged, step still pulses.
  - mask=0 in any mode: stays 0; steps still pulse and count.
- load has priority over tick in the same cycle:
  - mask <= mask_in, div_cnt <= 0, dir <= right.
  - No step pulse; step_cnt unchanged.
- A mode change takes effect at the next tick. div_cnt is not cleared except when entering hold or on load.
- step is low in every cycle not directly following a tick.
- Reset asserted mid-count aborts immediately. All state returns to reset values asynchronously and stays there while rst=1.

Test Plan:
- Reset: rst pulse with patt=4'hA, mode=00 -> out=16'hA000, step=0, step_cnt=0; out stays 16'hA000 for 20 cycles.
- Rotate left: mode=01, en=1, patt=4'hF -> step on cycles 4, 8, 12; out goes 16'hF000 -> 16'h000F -> 16'h00F0 -> 16'h0F00; step_cnt=3.
- Rotate right: load mask_in=4'b0011, mode=10, patt=4'h5 -> out goes 16'h0055 -> 16'h5005 -> 16'h5500 on successive steps.
- Bounce: load 4'b0100, mode=11 -> mask sequence 0010, 0001, 0010, 0100, 1000, 0100; then load 4'b1001 -> mask holds 1001 while steps still pulse.
- Load/tick collision: load 4'b0110 on the cycle div_cnt==3 -> mask=0110, no step; next step 4 enabled cycles later.
- en low for 5 cycles at div_cnt=2 -> count frozen, step arrives 2 enabled cycles after en returns. rst mid-count -> out=16'hF000 (patt=F), step_cnt=0.

Source files
------------

// File: rtl/led_group_sequencer.sv
// led_group_sequencer: steps a lit-group mask across GROUPS groups of GW LEDs.
// Rev 1.0 - hold / rotate-left / rotate-right / bounce modes with prescaled stepping.
`default_nettype none

module led_group_sequencer #(
  parameter int GROUPS = 4,
  parameter int GW     = 4,
  parameter int DIV    = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 load,
  input  logic [GROUPS-1:0]    mask_in,
  input  logic [1:0]           mode,
  input  logic [GW-1:0]        patt,
  output logic [GROUPS*GW-1:0] out,
  output logic                 step,
  output logic [7:0]           step_cnt
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_LEFT  = 2'b01;
  localparam logic [1:0] MODE_RIGHT = 2'b10;
  localparam logic [1:0] MODE_BNC   = 2'b11;

  typedef enum logic {
    DIR_RIGHT = 1'b0,
    DIR_LEFT  = 1'b1
  } dir_t;

  logic [GROUPS-1:0] mask, mask_nxt;
  dir_t              dir, dir_nxt;
  logic [CW-1:0]     div_cnt, div_cnt_nxt;
  logic              step_nxt;
  logic [7:0]        step_cnt_nxt;
  logic              tick;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask     <= {1'b1, {(GROUPS-1){1'b0}}};
      dir      <= DIR_RIGHT;
      div_cnt  <= '0;
      step     <= 1'b0;
      step_cnt <= 8'd0;
    end else begin
      mask     <= mask_nxt;
      dir      <= dir_nxt;
      div_cnt  <= div_cnt_nxt;
      step     <= step_nxt;
      step_cnt <= step_cnt_nxt;
    end
  end

  always_comb begin
    mask_nxt     = mask;
    dir_nxt      = dir;
    div_cnt_nxt  = div_cnt;
    step_nxt     = 1'b0;
    step_cnt_nxt = step_cnt;
    tick         = 1'b0;

    if (load) begin
      mask_nxt    = mask_in;
      div_cnt_nxt = '0;
      dir_nxt     = DIR_RIGHT;
    end else begin
      if (mode == MODE_HOLD) begin
        div_cnt_nxt = '0;
      end else if (en) begin
        if (div_cnt == CNT_LAST) begin
          div_cnt_nxt = '0;
          tick        = 1'b1;
        end else begin
          div_cnt_nxt = div_cnt + 1'b1;
        end
      end

      if (tick) begin
        step_nxt     = 1'b1;
        step_cnt_nxt = step_cnt + 8'd1;
        case (mode)
          MODE_LEFT:  mask_nxt = {mask[GROUPS-2:0], mask[GROUPS-1]};
          MODE_RIGHT: mask_nxt = {mask[0], mask[GROUPS-1:1]};
          MODE_BNC: begin
            // Both end groups lit: nowhere to move, so the mask is frozen.
            if (mask[0] && mask[GROUPS-1]) begin
              mask_nxt = mask;
            end else if (dir == DIR_RIGHT) begin
              if (mask[0]) begin
                dir_nxt  = DIR_LEFT;
                mask_nxt = mask << 1;
              end else begin
                mask_nxt = mask >> 1;
              end
            end else begin
              if (mask[GROUPS-1]) begin
                dir_nxt  = DIR_RIGHT;
                mask_nxt = mask >> 1;
              end else begin
                mask_nxt = mask << 1;
              end
            end
          end
          default: mask_nxt = mask;
        endcase
      end
    end
  end

  for (genvar g = 0; g < GROUPS; g++) begin : g_grp
    assign out[g*GW +: GW] = mask[g] ? patt : '0;
  end

endmodule

`default_nettype wire
